// File: rtl/sprite_engine.sv
// sprite_engine: erases, moves and redraws one rectangular sprite as a raster of pixel writes.
// Optional feature macro: SPRITE_BOUNCE_EN (clamped MOVE axes reflect the stored direction).
module sprite_engine #(
    parameter int unsigned SCR_W   = 160,
    parameter int unsigned SCR_H   = 120,
    parameter int unsigned SPR_W   = 4,
    parameter int unsigned SPR_H   = 4,
    parameter int unsigned STEP    = 1,
    parameter int unsigned START_X = 80,
    parameter int unsigned START_Y = 60,
    parameter int unsigned XW      = 8,
    parameter int unsigned YW      = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_dir,
    input  logic [2:0]    fg_colour,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [2:0]    colour,
    output logic          plot,
    output logic          done,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          flying,
    output logic [1:0]    dir_out
);

    localparam int unsigned MAX_X = SCR_W - SPR_W;
    localparam int unsigned MAX_Y = SCR_H - SPR_H;

    localparam logic [1:0] OP_NEW    = 2'b00;
    localparam logic [1:0] OP_MOVE   = 2'b01;
    localparam logic [1:0] OP_SHOT   = 2'b10;
    localparam logic [1:0] OP_ESCAPE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_UPDATE,
        S_DRAW,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [1:0]    op_q, op_d;
    logic [1:0]    cdir_q, cdir_d;
    logic [2:0]    col_q, col_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic          flying_q, flying_d;
    logic [1:0]    dir_q, dir_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;

    logic [31:0]   x_inc, y_inc;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [1:0]    mv_dir;

    assign x_inc = 32'(pos_x_q) + STEP;
    assign y_inc = 32'(pos_y_q) + STEP;

`ifdef SPRITE_BOUNCE_EN
    logic clamp_x, clamp_y;
    // Once bouncing is enabled, the sprite steers itself from its stored direction
    assign mv_dir  = dir_q;
    assign clamp_x = mv_dir[0] ? (x_inc > MAX_X) : (32'(pos_x_q) < STEP);
    assign clamp_y = mv_dir[1] ? (y_inc > MAX_Y) : (32'(pos_y_q) < STEP);
`else
    assign mv_dir  = cdir_q;
`endif

    // Clamped MOVE target position
    always_comb begin
        nx = pos_x_q;
        ny = pos_y_q;
        if (mv_dir[0]) begin
            nx = (x_inc > MAX_X) ? XW'(MAX_X) : XW'(x_inc);
        end else begin
            nx = (32'(pos_x_q) < STEP) ? '0 : XW'(32'(pos_x_q) - STEP);
        end
        if (mv_dir[1]) begin
            ny = (y_inc > MAX_Y) ? YW'(MAX_Y) : YW'(y_inc);
        end else begin
            ny = (32'(pos_y_q) < STEP) ? '0 : YW'(32'(pos_y_q) - STEP);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        op_d     = op_q;
        cdir_d   = cdir_q;
        col_d    = col_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        flying_d = flying_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cdir_d = cmd_dir;
                    col_d  = fg_colour;
                    ox_d   = '0;
                    oy_d   = '0;
                    // NEW and commands to a dead sprite have nothing to erase
                    if (cmd_op == OP_NEW || !flying_q) begin
                        state_d = S_UPDATE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end

            S_CLEAR, S_DRAW: begin
                plot_d   = 1'b1;
                x_d      = XW'(32'(pos_x_q) + 32'(ox_q));
                y_d      = YW'(32'(pos_y_q) + 32'(oy_q));
                colour_d = (state_q == S_DRAW) ? col_q : 3'b000;
                if (ox_q == XW'(SPR_W - 1)) begin
                    ox_d = '0;
                    if (oy_q == YW'(SPR_H - 1)) begin
                        oy_d    = '0;
                        state_d = (state_q == S_CLEAR) ? S_UPDATE : S_FINISH;
                    end else begin
                        oy_d = oy_q + YW'(1);
                    end
                end else begin
                    ox_d = ox_q + XW'(1);
                end
            end

            S_UPDATE: begin
                if (op_q == OP_NEW) begin
                    pos_x_d  = XW'(START_X);
                    pos_y_d  = YW'(START_Y);
                    flying_d = 1'b1;
                    dir_d    = cdir_q;
                    state_d  = S_DRAW;
                end else if (!flying_q) begin
                    state_d = S_FINISH;
`ifndef SPRITE_BOUNCE_EN
                    if (op_q == OP_MOVE) begin
                        dir_d = cdir_q;
                    end
`endif
                end else begin
                    unique case (op_q)
                        OP_MOVE: begin
                            pos_x_d = nx;
                            pos_y_d = ny;
`ifdef SPRITE_BOUNCE_EN
                            dir_d   = {mv_dir[1] ^ clamp_y, mv_dir[0] ^ clamp_x};
`else
                            dir_d   = cdir_q;
`endif
                            state_d = S_DRAW;
                        end
                        OP_SHOT: begin
                            if (y_inc > MAX_Y) begin
                                pos_y_d  = YW'(MAX_Y);
                                flying_d = 1'b0;
                                state_d  = S_FINISH;
                            end else begin
                                pos_y_d = YW'(y_inc);
                                state_d = S_DRAW;
                            end
                        end
                        OP_ESCAPE: begin
                            if (32'(pos_y_q) < STEP) begin
                                pos_y_d  = '0;
                                flying_d = 1'b0;
                                state_d  = S_FINISH;
                            end else begin
                                pos_y_d = YW'(32'(pos_y_q) - STEP);
                                state_d = S_DRAW;
                            end
                        end
                        default: state_d = S_FINISH;
                    endcase
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ox_q     <= '0;
            oy_q     <= '0;
            op_q     <= OP_NEW;
            cdir_q   <= 2'b00;
            col_q    <= 3'b000;
            pos_x_q  <= XW'(START_X);
            pos_y_q  <= YW'(START_Y);
            flying_q <= 1'b0;
            dir_q    <= 2'b00;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= 3'b000;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            op_q     <= op_d;
            cdir_q   <= cdir_d;
            col_q    <= col_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            flying_q <= flying_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign flying    = flying_q;
    assign dir_out   = dir_q;

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: directed + randomized command sequence checked against a per-command
// timeline model (expected plot/done cycle offsets, pixel list, final sprite state).
module tb_sprite_engine;

    localparam int unsigned SCR_W   = 160;
    localparam int unsigned SCR_H   = 120;
    localparam int unsigned SPR_W   = 4;
    localparam int unsigned SPR_H   = 4;
    localparam int unsigned STEP    = 1;
    localparam int unsigned START_X = 80;
    localparam int unsigned START_Y = 60;
    localparam int unsigned XW      = 8;
    localparam int unsigned YW      = 7;
    localparam int          N       = int'(SPR_W * SPR_H);
    localparam int          MAX_X   = int'(SCR_W - SPR_W);
    localparam int          MAX_Y   = int'(SCR_H - SPR_H);
    localparam int          MAX_K   = 2 * N + 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_dir;
    logic [2:0]    fg_colour;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [2:0]    colour;
    logic          plot;
    logic          done;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          flying;
    logic [1:0]    dir_out;

    sprite_engine #(
        .SCR_W(SCR_W), .SCR_H(SCR_H), .SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP),
        .START_X(START_X), .START_Y(START_Y), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .fg_colour(fg_colour),
        .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .done(done),
        .pos_x(pos_x), .pos_y(pos_y), .flying(flying), .dir_out(dir_out)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errs    = 0;

    // Reference sprite state
    int         m_x, m_y;
    bit         m_fly;
    logic [1:0] m_dir;

    // Expected per-cycle activity, indexed by cycles after the accepting edge
    bit         exp_plot [MAX_K+1];
    int         exp_x    [MAX_K+1];
    int         exp_y    [MAX_K+1];
    logic [2:0] exp_c    [MAX_K+1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic plan_pass(input int k0, input int px, input int py, input logic [2:0] c);
        for (int i = 0; i < N; i++) begin
            exp_plot[k0+i] = 1'b1;
            exp_x[k0+i]    = px + (i % int'(SPR_W));
            exp_y[k0+i]    = py + (i / int'(SPR_W));
            exp_c[k0+i]    = c;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pos_x"},   32'(pos_x),   32'(m_x));
        chk({tag, ".pos_y"},   32'(pos_y),   32'(m_y));
        chk({tag, ".flying"},  32'(flying),  32'(m_fly));
        chk({tag, ".dir_out"}, 32'(dir_out), 32'(m_dir));
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] dir, input logic [2:0] col,
                          input bit noise);
        int dk;
        int ox;
        int oy;
        for (int k = 0; k <= MAX_K; k++) exp_plot[k] = 1'b0;
        ox = m_x;
        oy = m_y;
        if (op == 2'b00) begin
            m_x = int'(START_X); m_y = int'(START_Y); m_fly = 1'b1; m_dir = dir;
            plan_pass(2, m_x, m_y, col);
            dk = N + 2;
        end else if (!m_fly) begin
            if (op == 2'b01) m_dir = dir;
            dk = 2;
        end else begin
            plan_pass(1, ox, oy, 3'b000);
            case (op)
                2'b01: begin
                    m_dir = dir;
                    if (dir[0]) m_x = (m_x + int'(STEP) > MAX_X) ? MAX_X : m_x + int'(STEP);
                    else        m_x = (m_x - int'(STEP) < 0) ? 0 : m_x - int'(STEP);
                    if (dir[1]) m_y = (m_y + int'(STEP) > MAX_Y) ? MAX_Y : m_y + int'(STEP);
                    else        m_y = (m_y - int'(STEP) < 0) ? 0 : m_y - int'(STEP);
                end
                2'b10: begin
                    if (m_y + int'(STEP) > MAX_Y) begin m_fly = 1'b0; m_y = MAX_Y; end
                    else m_y = m_y + int'(STEP);
                end
                default: begin
                    if (m_y < int'(STEP)) begin m_fly = 1'b0; m_y = 0; end
                    else m_y = m_y - int'(STEP);
                end
            endcase
            if (m_fly) plan_pass(N + 2, m_x, m_y, col);
            dk = m_fly ? 2 * N + 2 : N + 2;
        end

        @(negedge clk);
        chk("ready_before_accept", 32'(cmd_ready), 32'(1));
        cmd_op = op; cmd_dir = dir; fg_colour = col; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= dk; k++) begin
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_dir   = 2'($urandom);
                fg_colour = 3'($urandom);
            end
            @(posedge clk);
            #1;
            chk("plot",      32'(plot),      32'(exp_plot[k]));
            chk("done",      32'(done),      32'(k == dk));
            chk("cmd_ready", 32'(cmd_ready), 32'(k == dk));
            if (exp_plot[k]) begin
                chk("x_out",  32'(x_out),  32'(exp_x[k]));
                chk("y_out",  32'(y_out),  32'(exp_y[k]));
                chk("colour", 32'(colour), 32'(exp_c[k]));
            end
        end
        cmd_valid = 1'b0;
        check_state("after_cmd");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(1));
        chk({tag, ".plot"},      32'(plot),      32'(0));
        chk({tag, ".done"},      32'(done),      32'(0));
        chk({tag, ".x_out"},     32'(x_out),     32'(0));
        chk({tag, ".y_out"},     32'(y_out),     32'(0));
        chk({tag, ".colour"},    32'(colour),    32'(0));
        check_state(tag);
    endtask

    initial begin
        logic [1:0] rop;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 2'b00; fg_colour = 3'b000;
        m_x = int'(START_X); m_y = int'(START_Y); m_fly = 1'b0; m_dir = 2'b00;

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk) reset_n = 1'b1;

        // Spawn, then a single up-right step
        do_cmd(2'b00, 2'b01, 3'b111, 1'b0);
        do_cmd(2'b01, 2'b01, 3'b101, 1'b0);

        // Random walk with command noise during busy cycles
        for (int i = 0; i < 20; i++) do_cmd(2'b01, 2'($urandom), 3'($urandom), 1'b1);

        // Drive to the right edge, then push against it
        for (int i = 0; i < 200 && m_x < MAX_X; i++) do_cmd(2'b01, 2'b01, 3'b011, 1'b0);
        do_cmd(2'b01, 2'b01, 3'b110, 1'b0);
        chk("right_clamp", 32'(pos_x), 32'(MAX_X));

        // Drive to the top, escape, then commands to a dead sprite
        for (int i = 0; i < 200 && m_y > 0; i++) do_cmd(2'b01, 2'b00, 3'b001, 1'b0);
        do_cmd(2'b11, 2'b00, 3'b010, 1'b0);
        chk("escape_dead", 32'(flying), 32'(0));
        do_cmd(2'b01, 2'b11, 3'b010, 1'b1);
        do_cmd(2'b10, 2'b00, 3'b010, 1'b0);

        // Respawn and shoot down until it leaves the bottom
        do_cmd(2'b00, 2'b10, 3'b100, 1'b0);
        for (int i = 0; i < 200 && m_fly; i++) do_cmd(2'b10, 2'b00, 3'b100, 1'b0);
        chk("shot_bottom_y", 32'(pos_y), 32'(MAX_Y));
        do_cmd(2'b01, 2'b01, 3'b111, 1'b0);
        do_cmd(2'b11, 2'b00, 3'b111, 1'b0);

        // Random command mix
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            do_cmd(rop, 2'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a redraw
        do_cmd(2'b00, 2'b00, 3'b101, 1'b0);
        @(negedge clk);
        cmd_op = 2'b01; cmd_dir = 2'b10; fg_colour = 3'b011; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1 chk("plot_mid_draw", 32'(plot), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        m_x = int'(START_X); m_y = int'(START_Y); m_fly = 1'b0; m_dir = 2'b00;
        check_reset_outputs("mid_reset");
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #1;
            chk("post_reset_plot",  32'(plot),      32'(0));
            chk("post_reset_ready", 32'(cmd_ready), 32'(1));
        end
        do_cmd(2'b01, 2'b01, 3'b111, 1'b0);
        do_cmd(2'b00, 2'b11, 3'b110, 1'b0);
        do_cmd(2'b01, 2'b10, 3'b001, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 SHALL have parameter SCR_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCR_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter SPR_W, default 4, sprite width (>=1, <=SCR_W).
REQ-004 SHALL have parameter SPR_H, default 4, sprite height (>=1, <=SCR_H).
REQ-005 SHALL have parameter STEP, default 1, pixels moved per command (>=1).
REQ-006 SHALL have parameters START_X, default 80, and START_Y, default 60, spawn position.
REQ-007 SHALL have parameters XW, default 8, and YW, default 7, coordinate widths.
REQ-008 clk  in  1  clock; all state on rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 cmd_valid  in  1  command request.
REQ-011 cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge.
REQ-012 cmd_op  in  2  00 NEW, 01 MOVE, 10 SHOT, 11 ESCAPE.
REQ-013 cmd_dir  in  2  bit1=down(1)/up(0), bit0=right(1)/left(0); used by MOVE.
REQ-014 fg_colour  in  3  draw colour, sampled at acceptance.
REQ-015 x_out / y_out  out  XW / YW  current pixel coordinate.
REQ-016 colour  out  3  current pixel colour.
REQ-017 plot  out  1  pixel write strobe.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 pos_x / pos_y  out  XW / YW  sprite top-left position.
REQ-020 flying  out  1  sprite alive on screen.
REQ-021 dir_out  out  2  current direction.

Function
REQ-022 FSM states: IDLE, CLEAR, UPDATE, DRAW, FINISH.
REQ-023 Pixel pass (CLEAR or DRAW): N=SPR_W*SPR_H cycles, raster order, x offset inner, from (pos_x,pos_y); colour=000 in CLEAR, latched fg_colour in DRAW; plot=1 each pass cycle.
REQ-024 MOVE accepted at edge T: CLEAR pixels at T+1..T+N; UPDATE at T+N+1 (plot=0); DRAW pixels at T+N+2..T+2N+1; done=1 and cmd_ready=1 at T+2N+2 (FINISH then IDLE).
REQ-025 MOVE update: right x=min(x+STEP,SCR_W-SPR_W); left x=max(x-STEP,0); down y=min(y+STEP,SCR_H-SPR_H); up y=max(y-STEP,0); no wrap or underflow.
REQ-026 NEW: pos=(START_X,START_Y), flying=1, dir_out=cmd_dir; skips CLEAR; DRAW only; done at T+N+2.
REQ-027 SHOT: CLEAR, then y=y+STEP; if new y > SCR_H-SPR_H: flying=0, DRAW skipped, pos_y holds SCR_H-SPR_H.
REQ-028 ESCAPE: CLEAR, then if y < STEP: flying=0, DRAW skipped, pos_y=0; else y=y-STEP and DRAW.
REQ-029 MOVE/SHOT/ESCAPE with flying=0: no pixels, no position change; done pulse at T+2.
REQ-030 cmd_valid outside IDLE SHALL be ignored; no queuing.
REQ-031 plot=0, done=0 in all cycles not named above; x_out/y_out/colour hold last value.
REQ-032 Without the configured feature, dir_out SHALL equal cmd_dir of the last accepted NEW or MOVE.

Reset
REQ-033 reset_n low (any state, including mid-pass) SHALL immediately force IDLE, cmd_ready=1, plot=0, done=0, flying=0, pos=(START_X,START_Y), x_out=0, y_out=0, colour=000, dir_out=00; no pixels resumed after release.

Configuration
REQ-034 Macro SPRITE_BOUNCE_EN defined: on MOVE, each axis whose result was clamped SHALL have its dir_out bit inverted at UPDATE, and subsequent MOVE uses dir_out instead of cmd_dir; not defined: clamp only, REQ-032 applies.

Verification
REQ-035 Reset, NEW, fg_colour=111 -> 16 plots (80..83,60..63) colour 111, done 18 cycles after acceptance, flying=1.
REQ-036 MOVE dir=01 from (80,60) -> 16 clear plots at old spot, 16 draws at (81,59), done at T+34.
REQ-037 pos_x=156, MOVE right -> pos_x stays 156; with SPRITE_BOUNCE_EN dir_out[0] flips to 0 and next MOVE goes to 155.
REQ-038 pos_y=116, SHOT -> 16 clear plots, no draw, flying=0; following MOVE -> done at T+2, zero plots.
REQ-039 pos_y=0, ESCAPE -> clear, flying=0, pos_y=0; reset_n pulsed mid-DRAW of a MOVE -> plot drops same cycle, state per REQ-033.
